// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, opcodes, instruction classes, ALU ops.
package mc_pkg;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   localparam logic [6:0] OP_R   = 7'h33;
   localparam logic [6:0] OP_I   = 7'h13;
   localparam logic [6:0] OP_LW  = 7'h03;
   localparam logic [6:0] OP_SW  = 7'h23;
   localparam logic [6:0] OP_BEQ = 7'h63;
   localparam logic [6:0] OP_JAL = 7'h6F;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [2:0] {
      CL_R,
      CL_I,
      CL_LW,
      CL_SW,
      CL_BEQ,
      CL_JAL
   } cls_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct3/funct7[5] -> class, yEX op, illegal flag.
// Pure logic, no state; result is only consumed while the IR copy is stable.
module mc_decode
   import mc_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output cls_e       cls_o,
   output logic [2:0] op_o,
   output logic       illegal_o
);

   always_comb begin
      cls_o     = CL_R;
      op_o      = ALU_ADD;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_R, OP_I: begin
            cls_o = (opcode_i == OP_R) ? CL_R : CL_I;
            case (funct3_i)
               3'b000:  op_o = (opcode_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b111:  op_o = ALU_AND;
               3'b110:  op_o = ALU_OR;
               3'b010:  op_o = ALU_SLT;
               default: illegal_o = 1'b1;
            endcase
         end
         OP_LW:  cls_o = CL_LW;
         OP_SW:  cls_o = CL_SW;
         OP_BEQ: begin
            cls_o = CL_BEQ;
            op_o  = ALU_SUB;
         end
         OP_JAL: cls_o = CL_JAL;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, IR copy and retired-instruction counter.
// imem_rdy/dmem_rdy stretch FETCH/MEM; illegal encodings or misaligned targets park in TRAP until rst.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 'h28,
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  ins,
   input  logic             imem_rdy,
   input  logic             dmem_rdy,
   input  logic             zero,
   input  logic [XLEN-1:0]  branch,
   input  logic [XLEN-1:0]  jTarget,
   output logic [XLEN-1:0]  PC,
   output logic             ir_en,
   output logic             RegWrite,
   output logic             ALUSrc,
   output logic [2:0]       op,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             Mem2Reg,
   output logic             trap,
   output logic [CNT_W-1:0] instret
);

   localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [2:0]       state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [10:0]      ir_q, ir_d;        // {funct7[5], funct3, opcode}
   logic [CNT_W-1:0] instret_q, instret_d;

   cls_e             cls;
   logic [2:0]       dec_op;
   logic             illegal;
   logic [XLEN-1:0]  pc_inc, br_tgt, jal_tgt;
   logic             br_ok, jal_ok, retire, in_dp;
   logic             unused_ins;

   assign unused_ins = ^{ins[XLEN-1:31], ins[29:15], ins[11:7]};

   mc_decode u_decode (
      .opcode_i   (ir_q[6:0]),
      .funct3_i   (ir_q[9:7]),
      .funct7b5_i (ir_q[10]),
      .cls_o      (cls),
      .op_o       (dec_op),
      .illegal_o  (illegal)
   );

   assign pc_inc  = pc_q + PC_STEP;
   assign br_tgt  = zero ? pc_q + branch : pc_inc;
   assign jal_tgt = pc_q + jTarget;
   assign br_ok   = (br_tgt[1:0] == 2'b00);
   assign jal_ok  = (jal_tgt[1:0] == 2'b00);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      retire  = 1'b0;
      case (state_q)
         ST_FETCH: if (imem_rdy) begin
            ir_d    = {ins[30], ins[14:12], ins[6:0]};
            state_d = ST_DECODE;
         end
         ST_DECODE: state_d = illegal ? ST_TRAP : ST_EXEC;
         ST_EXEC: begin
            case (cls)
               CL_BEQ, CL_JAL: begin
                  // Misaligned target traps without touching PC or the counter.
                  if ((cls == CL_BEQ) ? br_ok : jal_ok) begin
                     pc_d    = (cls == CL_BEQ) ? br_tgt : jal_tgt;
                     retire  = 1'b1;
                     state_d = ST_FETCH;
                  end else begin
                     state_d = ST_TRAP;
                  end
               end
               CL_LW, CL_SW: state_d = ST_MEM;
               default:      state_d = ST_WB;
            endcase
         end
         ST_MEM: if (dmem_rdy) begin
            if (cls == CL_SW) begin
               pc_d    = pc_inc;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = ST_FETCH;
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_TRAP;
      endcase
      instret_d = retire ? instret_q + CNT_ONE : instret_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         instret_q <= instret_d;
      end
   end

   // ALU controls stay driven through MEM/WB so address and result remain stable.
   always_comb begin
      in_dp    = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);
      ir_en    = (state_q == ST_FETCH) && imem_rdy;
      ALUSrc   = in_dp && (cls inside {CL_I, CL_LW, CL_SW});
      op       = in_dp ? dec_op : ALU_ADD;
      MemRead  = (state_q == ST_MEM) && (cls == CL_LW);
      MemWrite = (state_q == ST_MEM) && (cls == CL_SW);
      Mem2Reg  = (state_q == ST_WB) && (cls == CL_LW);
      RegWrite = (state_q == ST_WB) || ((state_q == ST_EXEC) && (cls == CL_JAL) && jal_ok);
      trap     = (state_q == ST_TRAP);
   end

   assign PC      = pc_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl against an instruction-level reference model.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ins = '0, branch = '0, jTarget = '0;
   logic        imem_rdy = 1'b0, dmem_rdy = 1'b0, zero = 1'b0;

   logic [31:0] pc;
   logic        ir_en, reg_write, alu_src, mem_read, mem_write, mem2reg, trap;
   logic [2:0]  op;
   logic [15:0] instret;

   logic [31:0] d2_pc;
   logic        d2_ir_en, d2_reg_write, d2_alu_src, d2_mem_read, d2_mem_write, d2_mem2reg, d2_trap;
   logic [2:0]  d2_op;
   logic [1:0]  d2_instret;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc;
   int          m_cnt;

   always #5 clk = ~clk;

   mc_ctrl #(.XLEN(32), .RESET_PC(32'h28), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ins(ins), .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .zero(zero),
      .branch(branch), .jTarget(jTarget), .PC(pc), .ir_en(ir_en), .RegWrite(reg_write),
      .ALUSrc(alu_src), .op(op), .MemRead(mem_read), .MemWrite(mem_write), .Mem2Reg(mem2reg),
      .trap(trap), .instret(instret)
   );

   mc_ctrl #(.XLEN(32), .RESET_PC(32'h28), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .ins(ins), .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .zero(zero),
      .branch(branch), .jTarget(jTarget), .PC(d2_pc), .ir_en(d2_ir_en), .RegWrite(d2_reg_write),
      .ALUSrc(d2_alu_src), .op(d2_op), .MemRead(d2_mem_read), .MemWrite(d2_mem_write),
      .Mem2Reg(d2_mem2reg), .trap(d2_trap), .instret(d2_instret)
   );

   typedef struct packed {
      logic       done;
      logic [7:0] cyc, rw, rw_at, mr, mw, m2r, iren;
      logic       pc_stable;
      logic [2:0] op_rw;
      logic       src_rw;
   } obs_t;

   typedef struct packed {
      logic        traps;
      logic [7:0]  cyc, rw, mr, mw, m2r;
      logic [31:0] npc;
      logic        chk_op;
      logic [2:0]  op;
      logic        src;
   } exp_t;

   // Instruction-level reference: latency, strobe cycle counts and next PC from the ISA rules.
   function automatic exp_t model(input logic [31:0] instr, input logic z, input logic [31:0] br,
                                  input logic [31:0] jt, input int iw, input int dw, input logic [31:0] p);
      exp_t        e;
      logic [31:0] t;
      e     = '0;
      e.npc = p;
      case (instr[6:0])
         7'h33, 7'h13: begin
            e.chk_op = 1'b1;
            e.src    = (instr[6:0] == 7'h13);
            case (instr[14:12])
               3'b000:  e.op = (instr[6:0] == 7'h33 && instr[30]) ? 3'b110 : 3'b010;
               3'b111:  e.op = 3'b000;
               3'b110:  e.op = 3'b001;
               3'b010:  e.op = 3'b111;
               default: e.traps = 1'b1;
            endcase
            e.cyc = 8'd4; e.rw = 8'd1; e.npc = p + 32'd4;
         end
         7'h03: begin
            e.cyc = 8'(5 + dw); e.rw = 8'd1; e.mr = 8'(1 + dw); e.m2r = 8'd1; e.npc = p + 32'd4;
         end
         7'h23: begin
            e.cyc = 8'(4 + dw); e.mw = 8'(1 + dw); e.npc = p + 32'd4;
         end
         7'h63: begin
            t = z ? p + br : p + 32'd4;
            e.cyc = 8'd3;
            if (t[1:0] != 2'b00) e.traps = 1'b1; else e.npc = t;
         end
         7'h6F: begin
            t = p + jt;
            e.cyc = 8'd3;
            if (t[1:0] != 2'b00) e.traps = 1'b1; else begin e.npc = t; e.rw = 8'd1; end
         end
         default: e.traps = 1'b1;
      endcase
      if (e.traps) begin
         e.rw = '0; e.mr = '0; e.mw = '0; e.m2r = '0; e.npc = p;
      end
      e.cyc = e.cyc + 8'(iw);
      return e;
   endfunction

   function automatic logic [2:0] pick_f3();
      case ($urandom_range(0, 3))
         0:       return 3'b000;
         1:       return 3'b111;
         2:       return 3'b110;
         default: return 3'b010;
      endcase
   endfunction

   function automatic logic [31:0] gen_instr(input int c);
      logic [4:0] rd, rs1, rs2;
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      case (c)
         0:       return {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2, rs1, pick_f3(), rd, 7'h33};
         1:       return {12'($urandom), rs1, pick_f3(), rd, 7'h13};
         2:       return {12'($urandom), rs1, 3'b010, rd, 7'h03};
         3:       return {7'($urandom), rs2, rs1, 3'b010, 5'($urandom), 7'h23};
         4:       return {7'($urandom), rs2, rs1, 3'b000, 5'($urandom), 7'h63};
         default: return {20'($urandom), rd, 7'h6F};
      endcase
   endfunction

   function automatic logic [31:0] addi(input int imm);
      return {12'(imm), 5'd1, 3'b000, 5'd3, 7'h13};
   endfunction

   // Drives one instruction with the given memory waits; a simple data memory answers the strobes.
   task automatic run_instr(input logic [31:0] instr, input logic z, input logic [31:0] br,
                            input logic [31:0] jt, input int iw, input int dw, input int budget,
                            output obs_t o);
      logic [31:0] pc0;
      logic [15:0] cnt0;
      int          mc, k;
      o = '0; o.pc_stable = 1'b1; pc0 = pc; cnt0 = instret; mc = 0; k = 0;
      while (!o.done && k < budget) begin
         @(negedge clk);
         ins = instr; zero = z; branch = br; jTarget = jt;
         imem_rdy = (k < iw) ? 1'b0 : (k == iw) ? 1'b1 : 1'($urandom);
         #1;
         if (mem_read || mem_write) begin
            dmem_rdy = (mc >= dw);
            mc++;
         end else begin
            dmem_rdy = 1'($urandom);
         end
         #1;
         if (ir_en) o.iren = o.iren + 8'd1;
         if (reg_write) begin
            o.rw = o.rw + 8'd1; o.rw_at = 8'(k + 1); o.op_rw = op; o.src_rw = alu_src;
         end
         if (mem_read) o.mr = o.mr + 8'd1;
         if (mem_write) o.mw = o.mw + 8'd1;
         if (mem2reg && reg_write) o.m2r = o.m2r + 8'd1;
         if (pc !== pc0) o.pc_stable = 1'b0;
         @(posedge clk); #1;
         k++;
         if (instret !== cnt0) o.done = 1'b1;
      end
      o.cyc = 8'(k);
   endtask

   task automatic step(input logic [31:0] instr, input logic z, input logic [31:0] br, input logic [31:0] jt,
                       input int iw, input int dw, input int budget, output obs_t o, output exp_t e);
      e = model(instr, z, br, jt, iw, dw, m_pc);
      run_instr(instr, z, br, jt, iw, dw, budget, o);
      if (!e.traps) begin
         m_pc = e.npc;
         m_cnt++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; imem_rdy = 1'b0; dmem_rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_pc = 32'h28; m_cnt = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (pc !== 32'h28) begin errors++; $display("FAIL reset_pc: got %h want 00000028", pc); end
      checks++; if (instret !== 16'd0 || d2_instret !== 2'd0) begin errors++; $display("FAIL reset_instret: got %0d/%0d want 0", instret, d2_instret); end
      checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b want 0", trap); end
      checks++; if ({reg_write, mem_read, mem_write, mem2reg} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {reg_write, mem_read, mem_write, mem2reg}); end
      checks++; if (op !== 3'b010 || alu_src !== 1'b0) begin errors++; $display("FAIL reset_alu: op %b src %b want 010/0", op, alu_src); end
      @(negedge clk);
      rst = 1'b0; m_pc = 32'h28; m_cnt = 0;
   endtask

   task automatic test_add();
      obs_t o; exp_t e;
      step(32'h00208133, 1'b0, 32'd0, 32'd0, 0, 0, 20, o, e);
      checks++; if (o.cyc !== 8'd4 || !o.done) begin errors++; $display("FAIL add_latency: got %0d done %b want 4", o.cyc, o.done); end
      checks++; if (o.rw !== 8'd1 || o.rw_at !== 8'd4) begin errors++; $display("FAIL add_regwrite: got %0d pulses at %0d want 1 at 4", o.rw, o.rw_at); end
      checks++; if (o.op_rw !== 3'b010 || o.src_rw !== 1'b0) begin errors++; $display("FAIL add_alu: op %b src %b want 010/0", o.op_rw, o.src_rw); end
      checks++; if (pc !== 32'h2C || instret !== 16'd1) begin errors++; $display("FAIL add_retire: pc %h cnt %0d want 0000002c/1", pc, instret); end
   endtask

   task automatic test_lw();
      obs_t o; exp_t e;
      step({12'd8, 5'd1, 3'b010, 5'd5, 7'h03}, 1'b0, 32'd0, 32'd0, 0, 3, 30, o, e);
      checks++; if (o.cyc !== 8'd8) begin errors++; $display("FAIL lw_latency: got %0d want 8", o.cyc); end
      checks++; if (o.mr !== 8'd4) begin errors++; $display("FAIL lw_memread_hold: got %0d want 4", o.mr); end
      checks++; if (o.rw !== 8'd1 || o.m2r !== 8'd1 || o.rw_at !== 8'd8) begin errors++; $display("FAIL lw_wb: rw %0d m2r %0d at %0d want 1/1/8", o.rw, o.m2r, o.rw_at); end
      checks++; if (pc !== m_pc || instret !== 16'(m_cnt)) begin errors++; $display("FAIL lw_retire: pc %h cnt %0d want %h/%0d", pc, instret, m_pc, m_cnt); end
   endtask

   task automatic test_sw();
      obs_t o; exp_t e; int dw;
      dw = $urandom_range(0, 4);
      step({7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'h23}, 1'b0, 32'd0, 32'd0, 1, dw, 30, o, e);
      checks++; if (o.cyc !== e.cyc || o.mw !== e.mw) begin errors++; $display("FAIL sw_timing: cyc %0d mw %0d want %0d/%0d", o.cyc, o.mw, e.cyc, e.mw); end
      checks++; if (o.rw !== 8'd0 || o.mr !== 8'd0) begin errors++; $display("FAIL sw_no_write: rw %0d mr %0d want 0/0", o.rw, o.mr); end
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL sw_pc: got %h want %h", pc, m_pc); end
   endtask

   task automatic test_beq();
      obs_t o; exp_t e;
      do_reset();
      for (int i = 0; i < 10 && m_pc != 32'h40; i++) step(addi(i), 1'b0, 32'd0, 32'd0, 0, 0, 20, o, e);
      step({7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'h63}, 1'b0, 32'hFFFF_FFF8, 32'd0, 0, 0, 20, o, e);
      checks++; if (pc !== 32'h44 || o.cyc !== 8'd3 || o.rw !== 8'd0) begin errors++; $display("FAIL beq_not_taken: pc %h cyc %0d rw %0d want 00000044/3/0", pc, o.cyc, o.rw); end
      step({7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'h63}, 1'b1, 32'hFFFF_FFFC, 32'd0, 0, 0, 20, o, e);
      step({7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'h63}, 1'b1, 32'hFFFF_FFF8, 32'd0, 0, 0, 20, o, e);
      checks++; if (pc !== 32'h38 || o.cyc !== 8'd3 || o.rw !== 8'd0) begin errors++; $display("FAIL beq_taken: pc %h cyc %0d rw %0d want 00000038/3/0", pc, o.cyc, o.rw); end
      checks++; if (instret !== 16'(m_cnt)) begin errors++; $display("FAIL beq_instret: got %0d want %0d", instret, m_cnt); end
   endtask

   task automatic test_jal();
      obs_t o; exp_t e; int s;
      s = int'($urandom_range(1, 64)) - 32;
      step({20'd0, 5'd1, 7'h6F}, 1'b0, 32'd0, 32'(s * 4), 0, 0, 20, o, e);
      checks++; if (o.cyc !== 8'd3 || o.rw !== 8'd1 || o.rw_at !== 8'd3) begin errors++; $display("FAIL jal_timing: cyc %0d rw %0d at %0d want 3/1/3", o.cyc, o.rw, o.rw_at); end
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL jal_pc: got %h want %h", pc, m_pc); end
   endtask

   task automatic test_random();
      obs_t o; exp_t e; logic [31:0] instr, br, jt; int iw, dw;
      do_reset();
      for (int n = 0; n < 60; n++) begin
         instr = gen_instr($urandom_range(0, 5));
         br = 32'((int'($urandom_range(0, 63)) - 32) * 4);
         jt = 32'((int'($urandom_range(0, 63)) - 32) * 4);
         iw = $urandom_range(0, 2); dw = $urandom_range(0, 3);
         step(instr, 1'($urandom), br, jt, iw, dw, 40, o, e);
         checks++; if (!o.done || o.cyc !== e.cyc) begin errors++; $display("FAIL rnd_latency[%0d] %h: cyc %0d done %b want %0d", n, instr, o.cyc, o.done, e.cyc); end
         checks++; if (o.rw !== e.rw || o.mr !== e.mr || o.mw !== e.mw || o.m2r !== e.m2r) begin errors++; $display("FAIL rnd_strobes[%0d] %h: rw%0d mr%0d mw%0d m2r%0d want %0d/%0d/%0d/%0d", n, instr, o.rw, o.mr, o.mw, o.m2r, e.rw, e.mr, e.mw, e.m2r); end
         checks++; if (o.iren !== 8'd1 || !o.pc_stable) begin errors++; $display("FAIL rnd_fetch[%0d]: ir_en %0d pc_stable %b want 1/1", n, o.iren, o.pc_stable); end
         checks++; if (pc !== m_pc || instret !== 16'(m_cnt) || d2_instret !== 2'(m_cnt)) begin errors++; $display("FAIL rnd_retire[%0d]: pc %h cnt %0d/%0d want %h/%0d", n, pc, instret, d2_instret, m_pc, m_cnt); end
         if (e.chk_op) begin
            checks++; if (o.op_rw !== e.op || o.src_rw !== e.src) begin errors++; $display("FAIL rnd_alu[%0d] %h: op %b src %b want %b/%b", n, instr, o.op_rw, o.src_rw, e.op, e.src); end
         end
      end
   endtask

   task automatic test_wrap();
      obs_t o; exp_t e; int seq [5];
      seq = '{1, 2, 3, 0, 1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(addi(i + 1), 1'b0, 32'd0, 32'd0, 0, 0, 20, o, e);
         checks++; if (d2_instret !== 2'(seq[i])) begin errors++; $display("FAIL wrap[%0d]: got %0d want %0d", i, d2_instret, seq[i]); end
      end
   endtask

   task automatic test_misaligned();
      obs_t o; exp_t e; logic [31:0] pc0;
      do_reset();
      pc0 = pc;
      step({7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'h63}, 1'b1, 32'd2, 32'd0, 0, 0, 12, o, e);
      checks++; if (o.done || trap !== 1'b1 || pc !== pc0 || instret !== 16'(m_cnt)) begin errors++; $display("FAIL beq_misaligned: done %b trap %b pc %h cnt %0d want 0/1/%h/%0d", o.done, trap, pc, instret, pc0, m_cnt); end
      do_reset();
      step({20'd0, 5'd1, 7'h6F}, 1'b0, 32'd0, 32'd6, 0, 0, 12, o, e);
      checks++; if (o.done || trap !== 1'b1 || o.rw !== 8'd0 || pc !== 32'h28) begin errors++; $display("FAIL jal_misaligned: done %b trap %b rw %0d pc %h want 0/1/0/00000028", o.done, trap, o.rw, pc); end
   endtask

   task automatic test_illegal();
      obs_t o; exp_t e;
      do_reset();
      step(addi(5), 1'b0, 32'd0, 32'd0, 0, 0, 20, o, e);
      step(32'h0000_007F, 1'b0, 32'd0, 32'd0, 0, 0, 12, o, e);
      checks++; if (o.done || trap !== 1'b1 || d2_trap !== 1'b1) begin errors++; $display("FAIL illegal_opcode: done %b trap %b want 0/1", o.done, trap); end
      checks++; if (pc !== m_pc || instret !== 16'(m_cnt) || o.rw !== 8'd0) begin errors++; $display("FAIL illegal_frozen: pc %h cnt %0d rw %0d want %h/%0d/0", pc, instret, o.rw, m_pc, m_cnt); end
      do_reset();
      checks++; if (trap !== 1'b0) begin errors++; $display("FAIL trap_cleared: got %b want 0", trap); end
      step({7'd0, 5'd2, 5'd1, 3'b001, 5'd3, 7'h33}, 1'b0, 32'd0, 32'd0, 0, 0, 12, o, e);
      checks++; if (o.done || trap !== 1'b1 || pc !== 32'h28) begin errors++; $display("FAIL illegal_funct3: done %b trap %b pc %h want 0/1/00000028", o.done, trap, pc); end
   endtask

   task automatic test_rst_mid();
      obs_t o; exp_t e; logic seen;
      do_reset();
      step(addi(1), 1'b0, 32'd0, 32'd0, 0, 0, 20, o, e);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         ins = {7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'h23}; imem_rdy = 1'b1; dmem_rdy = 1'b0;
         #2;
         if (mem_write) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL rst_mid_reach_mem: got no MemWrite want MemWrite within 20 cycles"); end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (mem_write !== 1'b0 || reg_write !== 1'b0) begin errors++; $display("FAIL rst_mid_strobes: MemWrite %b RegWrite %b want 0/0", mem_write, reg_write); end
      checks++; if (pc !== 32'h28 || instret !== 16'd0) begin errors++; $display("FAIL rst_mid_state: pc %h cnt %0d want 00000028/0", pc, instret); end
      @(negedge clk);
      rst = 1'b0; m_pc = 32'h28; m_cnt = 0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_sw();
      test_jal();
      test_beq();
      test_random();
      test_wrap();
      test_misaligned();
      test_illegal();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
